// File: rtl/bus_stream_port_if.sv
// CPU bus and valid/ready stream signals of bus_stream_port, bundled for port connection.
// master = CPU and stream environment side, slave = the port itself.
interface bus_stream_port_if;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        RW;
    logic [7:0]  DI;
    logic        SEL;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;

    modport master (
        output AB, DO, RW, TX_READY, RX_DATA, RX_VALID,
        input  DI, SEL, TX_DATA, TX_VALID, RX_READY
    );

    modport slave (
        input  AB, DO, RW, TX_READY, RX_DATA, RX_VALID,
        output DI, SEL, TX_DATA, TX_VALID, RX_READY
    );
endinterface

// File: rtl/bus_stream_port.sv
// Memory-mapped stream port: CPU writes feed a TX FIFO, an inbound stream fills a one-byte RX register.
// Optional registered IRQ output is built when BUS_STREAM_PORT_IRQ_EN is defined.
module bus_stream_port #(
    parameter logic [15:0] BASE  = 16'hFF00,
    parameter int          DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    bus_stream_port_if.slave bus
`ifdef BUS_STREAM_PORT_IRQ_EN
    ,
    output logic             IRQ
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [1:0]    irq_en_q, irq_en_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_data_q, rx_data_d;

    reg_e       offset;
    logic       sel, wr_en, rd_en;
    logic       tx_empty, tx_full, tx_pop;
    logic       push_req, push_ok, ctrl_wr, flush;
    logic       rx_pop, rx_cap;
    logic [4:0] count_ext;
    logic [3:0] count_sat;
    logic [7:0] status;

    always_comb begin
        offset    = reg_e'(bus.AB[1:0]);
        sel       = (bus.AB[15:2] == BASE[15:2]);
        wr_en     = sel && bus.RW;
        rd_en     = sel && !bus.RW;

        tx_empty  = (count_q == '0);
        tx_full   = (count_q == CW'(DEPTH));
        tx_pop    = !tx_empty && bus.TX_READY;
        push_req  = wr_en && (offset == REG_DATA);
        // A full FIFO still takes a byte when the head leaves on the same edge.
        push_ok   = push_req && (!tx_full || tx_pop);
        ctrl_wr   = wr_en && (offset == REG_CTRL);
        flush     = ctrl_wr && bus.DO[1];

        rx_pop    = rd_en && (offset == REG_DATA) && rx_valid_q;
        rx_cap    = bus.RX_VALID && !rx_valid_q;

        count_ext = 5'(count_q);
        count_sat = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];
        status    = {count_sat, overflow_q, rx_valid_q, tx_empty, tx_full};
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (tx_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, tx_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (push_req && !push_ok)       overflow_d = 1'b1;
        else if (ctrl_wr && bus.DO[0])  overflow_d = 1'b0;
        if (ctrl_wr)                    irq_en_d   = bus.DO[3:2];

        if (rx_cap) begin
            rx_valid_d = 1'b1;
            rx_data_d  = bus.RX_DATA;
        end else if (rx_pop) begin
            rx_valid_d = 1'b0;
        end
    end

    always_comb begin
        bus.DI = 8'h00;
        if (rd_en) begin
            case (offset)
                REG_DATA:   bus.DI = rx_valid_q ? rx_data_q : 8'h00;
                REG_STATUS: bus.DI = status;
                REG_CTRL:   bus.DI = {4'h0, irq_en_q, 2'b00};
                default:    bus.DI = 8'h00;
            endcase
        end
    end

    assign bus.SEL      = sel;
    assign bus.TX_VALID = !tx_empty;
    assign bus.TX_DATA  = tx_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.RX_READY = !rx_valid_q;

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 2'b00;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // NOTE: FIFO storage has no reset; an empty FIFO gates TX_DATA, so stale bytes never show.
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.DO;
    end

`ifdef BUS_STREAM_PORT_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (irq_en_q[0] & rx_valid_q) | (irq_en_q[1] & tx_empty);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_bus_stream_port.sv
// Self-checking bench for bus_stream_port: register-access vector table, TX scoreboard, corner sequences.
// IRQ sequences run only when BUS_STREAM_PORT_IRQ_EN is defined.
module tb_bus_stream_port;

    localparam logic [15:0] A_DATA   = 16'hFF00;
    localparam logic [15:0] A_STATUS = 16'hFF01;
    localparam logic [15:0] A_CTRL   = 16'hFF02;
    localparam logic [15:0] A_RSVD   = 16'hFF03;

    logic CLK = 1'b0;
    logic RESET_N;

    bus_stream_port_if bus ();
`ifdef BUS_STREAM_PORT_IRQ_EN
    logic irq;
`endif

    bus_stream_port #(.BASE(16'hFF00), .DEPTH(8)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
`ifdef BUS_STREAM_PORT_IRQ_EN
        ,
        .IRQ     (irq)
`endif
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] tx_q [$];

    typedef struct {
        logic [15:0] ab;
        logic        rw;
        logic [7:0]  wdata;
        logic [7:0]  exp_di;
        logic        exp_sel;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.AB = 16'h0000;
        bus.RW = 1'b0;
        bus.DO = 8'h00;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input bit accept);
        bus.AB = a;
        bus.RW = 1'b1;
        bus.DO = d;
        if (accept) tx_q.push_back(d);
        step();
        idle();
    endtask

    task automatic bus_read(input string name, input logic [15:0] a, input logic [7:0] exp);
        bus.AB = a;
        bus.RW = 1'b0;
        @(negedge CLK);
        check(name, bus.DI, exp);
        step();
        idle();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (tx_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (tx_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: %0d bytes still queued, expected 0", name, tx_q.size());
        end
        @(negedge CLK);
        check_bit({name, "_tx_valid"}, bus.TX_VALID, 1'b0);
        step();
    endtask

    // TX consumer: every accepted handshake must match the oldest expected byte.
    always @(negedge CLK) begin
        if (RESET_N && bus.TX_VALID && bus.TX_READY) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL tx_unexpected: got %h expected no byte", bus.TX_DATA);
            end else begin
                check("tx_data", bus.TX_DATA, tx_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{16'hFF01, 1'b0, 8'h00, 8'h02, 1'b1};
        vecs[1]  = '{16'hFF02, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{16'hFF03, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[3]  = '{16'hFF00, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{16'hFF01, 1'b1, 8'hFF, 8'h00, 1'b1};
        vecs[5]  = '{16'hFF03, 1'b1, 8'h55, 8'h00, 1'b1};
        vecs[6]  = '{16'hFEFF, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{16'hFF04, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{16'h00FF, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{16'hFF01, 1'b0, 8'h00, 8'h02, 1'b1};
        vecs[10] = '{16'hFF02, 1'b1, 8'h0C, 8'h00, 1'b1};
        vecs[11] = '{16'hFF02, 1'b0, 8'h00, 8'h0C, 1'b1};
        vecs[12] = '{16'hFF02, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[13] = '{16'hFF02, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[14] = '{16'hFF01, 1'b0, 8'h00, 8'h02, 1'b1};

        idle();
        bus.TX_READY = 1'b0;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        RESET_N      = 1'b0;
        bus.AB       = 16'h1234;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        check_bit("rst_tx_valid", bus.TX_VALID, 1'b0);
        check_bit("rst_rx_ready", bus.RX_READY, 1'b1);
        check_bit("rst_sel", bus.SEL, 1'b0);
        check("rst_tx_data", bus.TX_DATA, 8'h00);
        check("rst_di", bus.DI, 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1;
        step();
        idle();
        bus_read("status_after_rst", A_STATUS, 8'h02);

        // Register access table
        for (int i = 0; i < 15; i++) begin
            bus.AB = vecs[i].ab;
            bus.RW = vecs[i].rw;
            bus.DO = vecs[i].wdata;
            @(negedge CLK);
            check($sformatf("vec%0d_di", i), bus.DI, vecs[i].exp_di);
            check_bit($sformatf("vec%0d_sel", i), bus.SEL, vecs[i].exp_sel);
            step();
        end
        idle();

        // TX fill past full, then drain in order
        for (int i = 0; i < 8; i++) bus_write(A_DATA, 8'(8'hA0 + i), 1'b1);
        @(negedge CLK);
        check_bit("fill_tx_valid", bus.TX_VALID, 1'b1);
        check("fill_head", bus.TX_DATA, 8'hA0);
        step();
        bus_read("status_full", A_STATUS, 8'h81);
        bus_write(A_DATA, 8'hA8, 1'b0);
        bus_read("status_overflow", A_STATUS, 8'h89);
        bus.TX_READY = 1'b1;
        wait_drain("drain_fill");
        bus.TX_READY = 1'b0;
        bus_read("status_sticky_ovf", A_STATUS, 8'h0A);
        bus_write(A_CTRL, 8'h01, 1'b0);
        bus_read("status_ovf_clear", A_STATUS, 8'h02);

        // Push into a full FIFO on the same cycle as a pop
        for (int i = 0; i < 8; i++) bus_write(A_DATA, 8'(8'hB0 + i), 1'b1);
        bus_read("status_full2", A_STATUS, 8'h81);
        bus.TX_READY = 1'b1;
        bus_write(A_DATA, 8'h55, 1'b1);
        bus.TX_READY = 1'b0;
        bus_read("status_pushpop", A_STATUS, 8'h81);
        bus.TX_READY = 1'b1;
        wait_drain("drain_pushpop");
        bus.TX_READY = 1'b0;

        // RX capture, hold while full, read and pop
        bus.RX_DATA  = 8'h3C;
        bus.RX_VALID = 1'b1;
        @(negedge CLK);
        check_bit("rx_ready_empty", bus.RX_READY, 1'b1);
        step();
        bus.RX_DATA = 8'h99;
        step();
        step();
        bus.RX_VALID = 1'b0;
        @(negedge CLK);
        check_bit("rx_ready_full", bus.RX_READY, 1'b0);
        step();
        bus_read("status_rx", A_STATUS, 8'h06);
        bus_read("rx_read", A_DATA, 8'h3C);
        bus_read("rx_read_empty", A_DATA, 8'h00);

        // Pop at edge N lets the next inbound byte land at N+1
        bus.RX_DATA  = 8'h11;
        bus.RX_VALID = 1'b1;
        step();
        bus.RX_DATA = 8'h22;
        bus.AB      = A_DATA;
        bus.RW      = 1'b0;
        @(negedge CLK);
        check("rx_b2b_first", bus.DI, 8'h11);
        check_bit("rx_b2b_busy", bus.RX_READY, 1'b0);
        step();
        idle();
        @(negedge CLK);
        check_bit("rx_ready_after_pop", bus.RX_READY, 1'b1);
        step();
        @(negedge CLK);
        check_bit("rx_recaptured", bus.RX_READY, 1'b0);
        step();
        bus.RX_VALID = 1'b0;
        bus_read("rx_b2b_second", A_DATA, 8'h22);

        // Flush with five bytes queued
        for (int i = 0; i < 5; i++) bus_write(A_DATA, 8'(8'hC0 + i), 1'b1);
        bus_read("status_five", A_STATUS, 8'h50);
        bus_write(A_CTRL, 8'h03, 1'b0);
        tx_q.delete();
        bus.AB = A_STATUS;
        bus.RW = 1'b0;
        @(negedge CLK);
        check("status_flushed", bus.DI, 8'h02);
        check_bit("flush_tx_valid", bus.TX_VALID, 1'b0);
        step();
        idle();
        bus.TX_READY = 1'b1;
        repeat (3) step();
        bus.TX_READY = 1'b0;
        bus_write(A_DATA, 8'hD1, 1'b1);
        bus_write(A_DATA, 8'hD2, 1'b1);
        bus.TX_READY = 1'b1;
        wait_drain("drain_after_flush");
        bus.TX_READY = 1'b0;

        // Reset mid-operation discards TX and RX contents at once
        bus_write(A_DATA, 8'hE0, 1'b1);
        bus_write(A_DATA, 8'hE1, 1'b1);
        bus.RX_DATA  = 8'h77;
        bus.RX_VALID = 1'b1;
        step();
        bus.RX_VALID = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        tx_q.delete();
        check_bit("midrst_tx_valid", bus.TX_VALID, 1'b0);
        check_bit("midrst_rx_ready", bus.RX_READY, 1'b1);
        check("midrst_tx_data", bus.TX_DATA, 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1;
        step();
        bus_read("status_midrst", A_STATUS, 8'h02);
        bus_read("rx_midrst", A_DATA, 8'h00);

`ifdef BUS_STREAM_PORT_IRQ_EN
        // RX-driven interrupt, one cycle behind the condition
        bus_write(A_CTRL, 8'h04, 1'b0);
        @(negedge CLK);
        check_bit("irq_idle", irq, 1'b0);
        step();
        bus.RX_DATA  = 8'h42;
        bus.RX_VALID = 1'b1;
        step();
        bus.RX_VALID = 1'b0;
        @(negedge CLK);
        check_bit("irq_at_capture", irq, 1'b0);
        step();
        @(negedge CLK);
        check_bit("irq_rise", irq, 1'b1);
        step();
        bus.AB = A_DATA;
        bus.RW = 1'b0;
        @(negedge CLK);
        check("irq_rx_read", bus.DI, 8'h42);
        step();
        idle();
        @(negedge CLK);
        check_bit("irq_after_pop", irq, 1'b1);
        step();
        @(negedge CLK);
        check_bit("irq_fall", irq, 1'b0);
        step();

        // TX-empty interrupt
        bus_write(A_CTRL, 8'h08, 1'b0);
        @(negedge CLK);
        check_bit("irq_tx_lag", irq, 1'b0);
        step();
        @(negedge CLK);
        check_bit("irq_tx_empty", irq, 1'b1);
        step();
        bus_write(A_CTRL, 8'h00, 1'b0);
        step();
        @(negedge CLK);
        check_bit("irq_disabled", irq, 1'b0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
